// File: rtl/bit_timer.sv
// Programmable bit timer: divides the clock into ticks and counts n_ticks of them per run.
// Optional midpoint pulse enabled by defining BIT_TIMER_MID_EN.
module bit_timer #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             start,
  input  logic             abort,
  input  logic [DIV_W-1:0] divisor,
  input  logic [CNT_W-1:0] n_ticks,
  output logic             busy,
  output logic             tick,
  output logic             mid,
  output logic [CNT_W-1:0] tick_count,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_l;
  logic [DIV_W-1:0] pre;
  logic [CNT_W-1:0] n_l;
  logic             zero_done;

  logic [DIV_W-1:0] div_last;
  logic [CNT_W-1:0] n_last;
  logic             last_tick;

  assign div_last  = div_l - DIV_W'(1);
  assign n_last    = n_l - CNT_W'(1);
  assign busy      = (state == RUN);
  assign tick      = busy && (pre == div_last);
  assign last_tick = tick && (tick_count == n_last);
  // A zero-length run reports completion from IDLE one cycle after its start.
  assign done      = (last_tick && !abort) || zero_done;

`ifdef BIT_TIMER_MID_EN
  assign mid = busy && (pre == (div_last >> 1));
`else
  assign mid = 1'b0;
`endif

  // Run-control state machine with prescaler and tick counter.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state      <= IDLE;
      div_l      <= DIV_W'(1);
      n_l        <= {CNT_W{1'b0}};
      pre        <= {DIV_W{1'b0}};
      tick_count <= {CNT_W{1'b0}};
      zero_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          zero_done <= 1'b0;
          if (start && !abort) begin
            div_l      <= (divisor == {DIV_W{1'b0}}) ? DIV_W'(1) : divisor;
            n_l        <= n_ticks;
            pre        <= {DIV_W{1'b0}};
            tick_count <= {CNT_W{1'b0}};
            if (n_ticks == {CNT_W{1'b0}}) begin
              zero_done <= 1'b1;
              state     <= IDLE;
            end else begin
              state <= RUN;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          zero_done <= 1'b0;
          if (abort || last_tick) begin
            state      <= IDLE;
            pre        <= {DIV_W{1'b0}};
            tick_count <= {CNT_W{1'b0}};
          end else if (tick) begin
            state      <= RUN;
            pre        <= {DIV_W{1'b0}};
            tick_count <= tick_count + CNT_W'(1);
          end else begin
            state <= RUN;
            pre   <= pre + DIV_W'(1);
          end
        end
        default: begin
          state      <= IDLE;
          pre        <= {DIV_W{1'b0}};
          tick_count <= {CNT_W{1'b0}};
          zero_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_timer.sv
// Scoreboard bench for bit_timer: stimulus pushes expected tick/mid/done events, a monitor pops and compares.
module tb_bit_timer;

`ifdef BIT_TIMER_MID_EN
  localparam bit MID = 1'b1;
`else
  localparam bit MID = 1'b0;
`endif

  logic        clock;
  logic        nreset;
  logic        start;
  logic        abort;
  logic [15:0] divisor;
  logic [3:0]  n_ticks;
  logic        busy;
  logic        tick;
  logic        mid;
  logic [3:0]  tick_count;
  logic        done;

  bit_timer #(.DIV_W(16), .CNT_W(4)) dut (
    .clock      (clock),
    .nreset     (nreset),
    .start      (start),
    .abort      (abort),
    .divisor    (divisor),
    .n_ticks    (n_ticks),
    .busy       (busy),
    .tick       (tick),
    .mid        (mid),
    .tick_count (tick_count),
    .done       (done)
  );

  typedef struct {
    int       cyc;
    logic     tk;
    logic     md;
    logic     dn;
    logic [3:0] tc;
  } ev_t;

  ev_t q[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  busy_cnt = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: an output window belongs to the clock edge that ends it (cyc+1).
  initial begin
    ev_t e;
    forever begin
      @(negedge clock);
      if (nreset) begin
        if (busy) busy_cnt++;
        if (tick || mid || done) begin
          if (q.size() == 0) begin
            check("unexpected_event", {32'(cyc + 1), tick, mid, done, tick_count}, 64'd0);
          end else begin
            e = q.pop_front();
            check("event", {32'(cyc + 1), tick, mid, done, tick_count},
                  {32'(e.cyc), e.tk, e.md, e.dn, e.tc});
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  // Expected events for windows s+1..s+stop of a run of n ticks at divisor dv.
  task automatic push_run(input int s, input int dv, input int n, input int stop);
    int  d;
    int  p;
    ev_t e;
    d = (dv == 0) ? 1 : dv;
    if (n == 0) begin
      e.cyc = s + 1; e.tk = 1'b0; e.md = 1'b0; e.dn = 1'b1; e.tc = 4'd0;
      q.push_back(e);
    end else begin
      for (int j = 1; j <= stop; j++) begin
        p     = (j - 1) % d;
        e.cyc = s + j;
        e.tk  = (p == d - 1);
        e.md  = MID && (p == (d - 1) / 2);
        e.dn  = e.tk && (j == d * n);
        e.tc  = 4'((j - 1) / d);
        if (e.tk || e.md || e.dn) q.push_back(e);
      end
    end
  endtask

  task automatic begin_run(input int dv, input int n, input int stop);
    int s;
    divisor  = 16'(dv);
    n_ticks  = 4'(n);
    start    = 1'b1;
    s        = cyc + 1;
    busy_cnt = 0;
    push_run(s, dv, n, stop);
    step();
    start = 1'b0;
  endtask

  initial begin
    nreset  = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    divisor = 16'd0;
    n_ticks = 4'd0;
    #3;
    check("reset_outputs", {busy, tick, mid, done, tick_count}, 64'd0);
    repeat (2) step();
    nreset = 1'b1;
    #1;
    check("post_reset_outputs", {busy, tick, mid, done, tick_count}, 64'd0);
    step();

    // Normal run with start/divisor/n_ticks changes mid-run and start in the done cycle.
    begin_run(16, 10, 160);
    for (int k = 1; k <= 159; k++) begin
      if (k == 50) begin
        start = 1'b1; divisor = 16'd3; n_ticks = 4'd1;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b1; divisor = 16'd4; n_ticks = 4'd2;
    step();
    start = 1'b0;
    repeat (8) step();
    check("normal_busy_cycles", 64'(busy_cnt), 64'd160);
    check("normal_drain", 64'(q.size()), 64'd0);
    check("normal_idle", {63'd0, busy}, 64'd0);

    begin_run(16, 2, 32);
    repeat (36) step();
    check("mid_busy_cycles", 64'(busy_cnt), 64'd32);
    check("mid_drain", 64'(q.size()), 64'd0);

    begin_run(0, 3, 3);
    repeat (6) step();
    check("div0_busy_cycles", 64'(busy_cnt), 64'd3);
    check("div0_drain", 64'(q.size()), 64'd0);

    begin_run(5, 0, 0);
    repeat (4) step();
    check("n0_busy_cycles", 64'(busy_cnt), 64'd0);
    check("n0_drain", 64'(q.size()), 64'd0);

    // Abort at cycle 20 of an 8x4 run, then a full run.
    begin_run(8, 4, 20);
    repeat (19) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    #1;
    check("abort_idle", {62'd0, busy, done}, 64'd0);
    repeat (4) step();
    check("abort_busy_cycles", 64'(busy_cnt), 64'd20);
    check("abort_drain", 64'(q.size()), 64'd0);
    begin_run(8, 4, 32);
    repeat (36) step();
    check("after_abort_busy_cycles", 64'(busy_cnt), 64'd32);
    check("after_abort_drain", 64'(q.size()), 64'd0);

    busy_cnt = 0;
    divisor = 16'd4; n_ticks = 4'd2; abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    repeat (10) step();
    check("abort_start_busy_cycles", 64'(busy_cnt), 64'd0);
    check("abort_start_drain", 64'(q.size()), 64'd0);

    // Reset at cycle 5 of a run, then a run with new settings.
    begin_run(16, 4, 4);
    repeat (4) step();
    nreset = 1'b0;
    #1;
    check("midrun_reset_outputs", {busy, tick, mid, done, tick_count}, 64'd0);
    step();
    step();
    nreset = 1'b1;
    #1;
    check("after_reset_outputs", {busy, tick, mid, done, tick_count}, 64'd0);
    check("reset_busy_cycles", 64'(busy_cnt), 64'd4);
    check("reset_drain", 64'(q.size()), 64'd0);
    step();
    begin_run(3, 2, 6);
    repeat (9) step();
    check("post_reset_busy_cycles", 64'(busy_cnt), 64'd6);
    check("post_reset_drain", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
